// File: rtl/fp32_pkg.sv
// Shared definitions for the single-precision normalize-and-round datapath.
package fp32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CARRY = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [7:0] FP32_EXP_MAX = 8'hFF;
    localparam int         FP32_BIAS    = 127;
    localparam int         FP32_MAN_W   = 24;

endpackage

// File: rtl/rne_round24.sv
// Round-to-nearest-even of a 24-bit significand given guard/round/sticky bits.
module rne_round24 (
    input  logic [23:0] m_i,
    input  logic [2:0]  g_i,
    output logic [23:0] m_o,
    output logic        carry_o,
    output logic        inexact_o
);

    logic        inc;
    logic [24:0] sum;

    assign inc       = g_i[2] & (g_i[1] | g_i[0] | m_i[0]);
    assign sum       = {1'b0, m_i} + {24'b0, inc};
    assign carry_o   = sum[24];
    // A carry out of the significand renormalizes to exactly 1.0.
    assign m_o       = sum[24] ? 24'h800000 : sum[23:0];
    assign inexact_o = |g_i;

endmodule

// File: rtl/normalize_and_round32.sv
// Normalizes a raw single-precision sum, rounds it to nearest-even and packs it.
module normalize_and_round32
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_man,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_zero,
    output logic        out_inexact,
    output logic [2:0]  dbg_state_o
);

    localparam logic [4:0] MAX_SHIFT = 5'(FP32_MAN_W - 1);

    state_e      state_q;
    logic        s_q;
    logic [8:0]  e_q;
    logic [24:0] m_q;
    logic [2:0]  g_q;
    logic [4:0]  cnt_q;
    logic        out_valid_q;
    logic [31:0] result_q;
    logic        ovf_q;
    logic        zero_q;
    logic        inx_q;

    logic [23:0] m_rnd;
    logic        rnd_carry;
    logic        rnd_inexact;
    logic [8:0]  e_rnd;

    rne_round24 u_round (
        .m_i       (m_q[23:0]),
        .g_i       (g_q),
        .m_o       (m_rnd),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    assign e_rnd = e_q + {8'b0, rnd_carry};

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    assign in_ready     = (state_q == ST_IDLE) & ~rst;
    assign out_valid    = out_valid_q;
    assign out_result   = result_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
    assign out_inexact  = inx_q;
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= 1'b0;
            e_q         <= 9'd0;
            m_q         <= 25'd0;
            g_q         <= 3'd0;
            cnt_q       <= 5'd0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_q   <= in_sign;
                        e_q   <= (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                        m_q   <= in_man;
                        g_q   <= in_grs;
                        cnt_q <= 5'd0;
                        ovf_q <= 1'b0;
                        inx_q <= 1'b0;
                        zero_q <= 1'b0;
                        if (in_exp == FP32_EXP_MAX) begin
                            result_q    <= {in_sign, FP32_EXP_MAX, in_man[22:0]};
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (in_man == 25'd0 && in_grs == 3'd0) begin
                            result_q    <= {in_sign, 31'b0};
                            zero_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (in_man[24]) begin
                            state_q <= ST_CARRY;
                        end else begin
                            state_q <= ST_NORM;
                        end
                    end
                end
                ST_CARRY: begin
                    m_q     <= {1'b0, m_q[24:1]};
                    g_q     <= {m_q[0], g_q[2], g_q[1] | g_q[0]};
                    e_q     <= e_q + 9'd1;
                    state_q <= ST_ROUND;
                end
                ST_NORM: begin
                    // Stop at the hidden bit, at the minimum exponent (subnormal), or at the shift limit.
                    if (m_q[23] || e_q == 9'd1 || cnt_q == MAX_SHIFT) begin
                        state_q <= ST_ROUND;
                    end else begin
                        m_q   <= {m_q[23:0], g_q[2]};
                        g_q   <= {g_q[1], g_q[0], 1'b0};
                        e_q   <= e_q - 9'd1;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_ROUND: begin
                    m_q   <= {1'b0, m_rnd};
                    e_q   <= e_rnd;
                    inx_q <= rnd_inexact;
                    if (e_rnd >= 9'd255) begin
                        result_q <= {s_q, FP32_EXP_MAX, 23'b0};
                        ovf_q    <= 1'b1;
                    end else begin
                        result_q <= {s_q, (m_rnd[23] ? e_rnd[7:0] : 8'd0), m_rnd[22:0]};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_and_round32.sv
// Directed scoreboard bench for normalize_and_round32.
module tb_normalize_and_round32;
    import fp32_pkg::*;

    localparam int W = 43;  // {result[31:0], ovf, zero, inexact, latency[7:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_zero;
    logic        out_inexact;
    logic [2:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    normalize_and_round32 dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_man       (in_man),
        .in_grs       (in_grs),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_inexact  (out_inexact),
        .dbg_state_o  (dbg_state)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares each new output presentation against the queue head
    logic         seen = 1'b0;
    logic [W-1:0] cur;
    int           acc;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_result);
                end else begin
                    cur = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check("result", 64'(out_result), 64'(cur[42:11]));
                    check("flags", 64'({out_overflow, out_zero, out_inexact}), 64'(cur[10:8]));
                    check("latency", 64'(cyc - acc + 1), 64'(cur[7:0]));
                end
            end
            if (out_ready) seen = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sign, input logic [7:0] e, input logic [24:0] man,
                        input logic [2:0] grs, input logic push, input logic [31:0] res,
                        input logic [2:0] flags, input int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        in_valid = 1'b1;
        in_sign  = sign;
        in_exp   = e;
        in_man   = man;
        in_grs   = grs;
        if (push) begin
            exp_q.push_back({res, flags, 8'(lat)});
            acc_q.push_back(cyc + 1);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run(input logic sign, input logic [7:0] e, input logic [24:0] man,
                       input logic [2:0] grs, input logic [31:0] res,
                       input logic [2:0] flags, input int lat);
        send(sign, e, man, grs, 1'b1, res, flags, lat);
        wait_drain();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = 8'd0;
        in_man = 25'd0;
        in_grs = 3'd0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_flags", 64'({out_overflow, out_zero, out_inexact}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed vectors: sign, exp, man, grs -> result, {ovf,zero,inexact}, latency
        run(1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 3);
        run(1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 3'b000, 26);
        run(1'b1, 8'h55,  25'h0000000, 3'b000, 32'h80000000, 3'b010, 1);
        run(1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001, 3);
        run(1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001, 3);
        run(1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b100, 3);
        run(1'b0, 8'hFF,  25'h0400000, 3'b111, 32'h7FC00000, 3'b000, 1);
        run(1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 3'b001, 3);
        run(1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 32'h40000000, 3'b001, 3);
        run(1'b0, 8'd127, 25'h0400000, 3'b100, 32'h3F000001, 3'b000, 4);
        run(1'b0, 8'd0,   25'h0000010, 3'b000, 32'h00000010, 3'b000, 3);
        run(1'b0, 8'd0,   25'h07FFFFF, 3'b110, 32'h00800000, 3'b001, 3);
        run(1'b0, 8'd3,   25'h0000100, 3'b000, 32'h00000400, 3'b000, 5);
        run(1'b1, 8'd130, 25'h0C00000, 3'b000, 32'hC1400000, 3'b000, 3);

        // Backpressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        send(1'b0, 8'd127, 25'h1000000, 3'b000, 1'b1, 32'h40000000, 3'b000, 3);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(out_result), 64'h40000000);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_valid_drop", 64'(out_valid), 64'd0);
        wait_drain();

        // Reset in the middle of normalization abandons the operation
        send(1'b0, 8'd127, 25'h0000001, 3'b000, 1'b0, 32'h0, 3'b000, 0);
        step();
        step();
        check("mid_norm_state", 64'(dbg_state), 64'(ST_NORM));
        rst = 1'b1;
        step();
        check("norm_rst_valid", 64'(out_valid), 64'd0);
        check("norm_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("norm_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("norm_rst_release", 64'(in_ready), 64'd1);
        for (int i = 0; i < 30; i++) step();

        // Reset while holding a result in DONE
        out_ready = 1'b0;
        send(1'b1, 8'd10, 25'h0000000, 3'b000, 1'b1, 32'h80000000, 3'b010, 1);
        step();
        check("done_hold_state", 64'(dbg_state), 64'(ST_DONE));
        rst = 1'b1;
        step();
        check("done_rst_valid", 64'(out_valid), 64'd0);
        check("done_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("done_rst_no_output", 64'(out_valid), 64'd0);

        // One more normal transaction after the reset sequences
        run(1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001, 3);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
